// File: rtl/mux4_rr_arbiter_pkg.sv
// Shared definitions for the 4-source round-robin arbiter / data mux.
//   NUM_REQ          : number of request sources
//   MAX_HOLD_DEFAULT : default cap on consecutive grant cycles per owner
//   state_t          : arbiter FSM state encoding
//   onehot4()        : index -> one-hot grant vector
package mux4_rr_arbiter_pkg;

    localparam int NUM_REQ          = 4;
    localparam int MAX_HOLD_DEFAULT = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    function automatic logic [NUM_REQ-1:0] onehot4(input logic [1:0] idx);
        logic [NUM_REQ-1:0] v;
        v = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/mux4_rr_arbiter_rr_pick.sv
// Combinational round-robin picker.
//   req    : per-source request vector
//   last   : most recently granted source
//   winner : first requesting source searching from last+1, wrapping
//   any    : at least one request is asserted
// When nothing requests, winner is simply last and must be ignored.
module rr_pick
    import mux4_rr_arbiter_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic [1:0]         last,
    output logic [1:0]         winner,
    output logic               any
);

    logic [1:0] idx;
    logic       found;

    // k = 4 lands back on last itself, so a lone requester re-wins.
    always_comb begin
        winner = last;
        found  = 1'b0;
        idx    = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = last + k[1:0];
            if (!found && req[idx]) begin
                winner = idx;
                found  = 1'b1;
            end
        end
    end

    assign any = |req;

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Four-source round-robin arbiter with a registered one-hot grant and a
// data mux that forwards the current owner's data word.
//   clock  : single clock, rising edge
//   reset  : synchronous, active-high
//   req    : level-sensitive requests, bit i = source i
//   X0..X3 : data words from sources 0..3
//   grant  : registered one-hot grant, zero when idle
//   sel    : registered owner index, holds last owner while idle
//   busy   : high in GRANT
//   F      : X[sel] while busy, zero otherwise
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | no owner; grant = 0, waiting for any request
// GRANT | sel owns the bus; cnt counts cycles held beyond the first
module mux4_rr_arbiter
    import mux4_rr_arbiter_pkg::*;
#(
    parameter int MAX_HOLD = MAX_HOLD_DEFAULT,
    parameter int DATA_W   = 2
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] req,
    input  logic [DATA_W-1:0]  X0,
    input  logic [DATA_W-1:0]  X1,
    input  logic [DATA_W-1:0]  X2,
    input  logic [DATA_W-1:0]  X3,
    output logic [NUM_REQ-1:0] grant,
    output logic [1:0]         sel,
    output logic               busy,
    output logic [DATA_W-1:0]  F
);

    localparam int CNT_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_HOLD - 1);

    state_t             state_q, state_d;
    logic [1:0]         sel_q, sel_d;
    logic [1:0]         last_q, last_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [1:0]         winner;
    logic               any;
    logic               rel_now;

    rr_pick u_rr_pick (
        .req    (req),
        .last   (last_q),
        .winner (winner),
        .any    (any)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            sel_q   <= 2'd0;
            last_q  <= 2'd3;   // makes source 0 the first pick after reset
            cnt_q   <= '0;
            grant_q <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            grant_q <= grant_d;
        end
    end

    // In GRANT last_q always equals sel_q, so a release re-runs the
    // round-robin search from the owner; an expiring lone owner wraps back
    // to itself and keeps a steady grant.
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        grant_d = grant_q;
        rel_now = !req[sel_q] || (cnt_q == CNT_LAST);

        case (state_q)
            IDLE: begin
                grant_d = '0;
                if (any) begin
                    state_d = GRANT;
                    sel_d   = winner;
                    last_d  = winner;
                    cnt_d   = '0;
                    grant_d = onehot4(winner);
                end
            end
            GRANT: begin
                if (!rel_now) begin
                    cnt_d = cnt_q + 1'b1;
                end else if (any) begin
                    sel_d   = winner;
                    last_d  = winner;
                    cnt_d   = '0;
                    grant_d = onehot4(winner);
                end else begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    grant_d = '0;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                grant_d = '0;
            end
        endcase
    end

    assign grant = grant_q;
    assign sel   = sel_q;
    assign busy  = (state_q == GRANT);

    always_comb begin
        F = '0;
        if (busy) begin
            case (sel_q)
                2'd0:    F = X0;
                2'd1:    F = X1;
                2'd2:    F = X2;
                default: F = X3;
            endcase
        end
    end

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
module tb_mux4_rr_arbiter;

    localparam int MAX_HOLD = 4;
    localparam int DATA_W   = 8;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic [3:0]        req   = 4'b0000;
    logic [DATA_W-1:0] x0 = 8'hA0;
    logic [DATA_W-1:0] x1 = 8'hB1;
    logic [DATA_W-1:0] x2 = 8'hC2;
    logic [DATA_W-1:0] x3 = 8'hD3;
    logic [3:0]        grant;
    logic [1:0]        sel;
    logic              busy;
    logic [DATA_W-1:0] F;

    int checks = 0;
    int errors = 0;

    mux4_rr_arbiter #(
        .MAX_HOLD (MAX_HOLD),
        .DATA_W   (DATA_W)
    ) dut (
        .clock (clock),
        .reset (reset),
        .req   (req),
        .X0    (x0),
        .X1    (x1),
        .X2    (x2),
        .X3    (x3),
        .grant (grant),
        .sel   (sel),
        .busy  (busy),
        .F     (F)
    );

    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req   = 4'b0000;
        step();
        reset = 1'b0;
    endtask

    function automatic logic [DATA_W-1:0] xval(input logic [1:0] s);
        case (s)
            2'd0:    return x0;
            2'd1:    return x1;
            2'd2:    return x2;
            default: return x3;
        endcase
    endfunction

    task automatic test_reset();
        reset = 1'b1;
        req   = 4'b1111;
        step();
        checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL reset_grant got %b want 0000", grant); end
        checks++; if (sel !== 2'd0) begin errors++; $display("FAIL reset_sel got %0d want 0", sel); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (F !== 8'h00) begin errors++; $display("FAIL reset_F got %h want 00", F); end
        reset = 1'b0;
        #2;
        checks++; if (F !== 8'h00) begin errors++; $display("FAIL post_reset_F got %h want 00", F); end
        step();
        checks++; if (grant !== 4'b0001) begin errors++; $display("FAIL first_grant got %b want 0001", grant); end
        checks++; if (F !== 8'hA0) begin errors++; $display("FAIL first_F got %h want a0", F); end
        req = 4'b0000;
        step();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL drop_to_idle busy got %b want 0", busy); end
    endtask

    task automatic test_alternate();
        logic [3:0]        exp_g;
        logic [DATA_W-1:0] exp_f;
        do_reset();
        req = 4'b0101;
        for (int i = 0; i < 16; i++) begin
            step();
            exp_g = ((i / 4) % 2 == 1) ? 4'b0100 : 4'b0001;
            exp_f = ((i / 4) % 2 == 1) ? 8'hC2 : 8'hA0;
            checks++; if (grant !== exp_g) begin errors++; $display("FAIL alternate_grant cyc %0d got %b want %b", i, grant, exp_g); end
            checks++; if (F !== exp_f) begin errors++; $display("FAIL alternate_F cyc %0d got %h want %h", i, F, exp_f); end
        end
        req = 4'b0000;
        step();
    endtask

    task automatic test_release();
        do_reset();
        req = 4'b0010;
        step();
        checks++; if (grant !== 4'b0010) begin errors++; $display("FAIL release_grant1 got %b want 0010", grant); end
        step();
        checks++; if (grant !== 4'b0010) begin errors++; $display("FAIL release_grant2 got %b want 0010", grant); end
        req = 4'b0000;
        step();
        checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL release_idle_grant got %b want 0000", grant); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL release_idle_busy got %b want 0", busy); end
        checks++; if (F !== 8'h00) begin errors++; $display("FAIL release_idle_F got %h want 00", F); end
        checks++; if (sel !== 2'd1) begin errors++; $display("FAIL release_idle_sel got %0d want 1", sel); end
    endtask

    task automatic test_single_regrant();
        do_reset();
        req = 4'b1000;
        for (int i = 0; i < 10; i++) begin
            step();
            checks++; if (grant !== 4'b1000) begin errors++; $display("FAIL regrant_grant cyc %0d got %b want 1000", i, grant); end
            checks++; if (busy !== 1'b1) begin errors++; $display("FAIL regrant_busy cyc %0d got %b want 1", i, busy); end
            checks++; if (F !== 8'hD3) begin errors++; $display("FAIL regrant_F cyc %0d got %h want d3", i, F); end
        end
        req = 4'b0000;
        step();
    endtask

    task automatic test_rotation();
        logic [1:0] order [4];
        logic [3:0] exp_g;
        order[0] = 2'd2; order[1] = 2'd3; order[2] = 2'd0; order[3] = 2'd1;
        do_reset();
        req = 4'b0010;
        step();
        checks++; if (grant !== 4'b0010) begin errors++; $display("FAIL rotation_start got %b want 0010", grant); end
        req = 4'b1111;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++; if (grant !== 4'b0010) begin errors++; $display("FAIL rotation_owner1 cyc %0d got %b want 0010", i, grant); end
        end
        for (int o = 0; o < 4; o++) begin
            exp_g = 4'b0001 << order[o];
            for (int j = 0; j < 4; j++) begin
                step();
                checks++; if (grant !== exp_g) begin errors++; $display("FAIL rotation_grant slot %0d cyc %0d got %b want %b", o, j, grant, exp_g); end
                checks++; if (sel !== order[o]) begin errors++; $display("FAIL rotation_sel slot %0d cyc %0d got %0d want %0d", o, j, sel, order[o]); end
            end
        end
        req = 4'b0000;
        step();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rotation_end_busy got %b want 0", busy); end
    endtask

    task automatic test_reset_mid_grant();
        do_reset();
        req = 4'b0100;
        step();
        step();
        checks++; if (grant !== 4'b0100) begin errors++; $display("FAIL midrst_pre got %b want 0100", grant); end
        reset = 1'b1;
        step();
        checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL midrst_grant got %b want 0000", grant); end
        checks++; if (sel !== 2'd0) begin errors++; $display("FAIL midrst_sel got %0d want 0", sel); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got %b want 0", busy); end
        reset = 1'b0;
        req   = 4'b1111;
        step();
        checks++; if (grant !== 4'b0001) begin errors++; $display("FAIL midrst_first got %b want 0001", grant); end
        req = 4'b0000;
        step();
    endtask

    task automatic test_random();
        int         waitc [4];
        int         worst;
        logic [3:0] applied;
        logic [DATA_W-1:0] exp_f;
        for (int i = 0; i < 4; i++) waitc[i] = 0;
        do_reset();
        for (int c = 0; c < 1200; c++) begin
            applied = 4'($urandom_range(0, 15));
            req = applied;
            x0 = 8'($urandom); x1 = 8'($urandom); x2 = 8'($urandom); x3 = 8'($urandom);
            step();
            checks++; if (!$onehot0(grant)) begin errors++; $display("FAIL rand_onehot cyc %0d got %b want one-hot or zero", c, grant); end
            checks++; if (busy !== (|grant)) begin errors++; $display("FAIL rand_busy cyc %0d got %b want %b", c, busy, |grant); end
            exp_f = busy ? xval(sel) : '0;
            checks++; if (F !== exp_f) begin errors++; $display("FAIL rand_F cyc %0d got %h want %h", c, F, exp_f); end
            if (busy) begin
                checks++; if (grant !== (4'b0001 << sel)) begin errors++; $display("FAIL rand_grant_sel cyc %0d got %b sel %0d", c, grant, sel); end
            end
            worst = 0;
            for (int i = 0; i < 4; i++) begin
                if (applied[i] && !grant[i]) waitc[i]++;
                else waitc[i] = 0;
                if (waitc[i] > worst) worst = waitc[i];
            end
            checks++; if (worst > 3 * MAX_HOLD + 1) begin errors++; $display("FAIL rand_wait cyc %0d got %0d want <= %0d", c, worst, 3 * MAX_HOLD + 1); end
        end
        req = 4'b0000;
        x0 = 8'hA0; x1 = 8'hB1; x2 = 8'hC2; x3 = 8'hD3;
        step();
    endtask

    initial begin
        test_reset();
        test_alternate();
        test_release();
        test_single_regrant();
        test_rotation();
        test_reset_mid_grant();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
